// File: rtl/sqrt_station_vec.sv
// Square-root station: N-cycle bit-serial restoring sqrt on 3 lanes, results queued for commit.
// Issue blocks while busy or when every queue slot is reserved; commit holds its head until granted.
module sqrt_station_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

module sqrt_station_vec #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int DEPTH = 2,
  parameter int DST_W = 8,
  parameter int ID_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    id,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic               issue_vector,
  input  logic [DST_W-1:0]   issue_dst,
  input  logic [2:0]         issue_we,
  input  logic [3*WIDTH-1:0] operand,
  output logic               commit_request,
  input  logic               commit_granted,
  output logic [ID_W-1:0]    commit_id,
  output logic [DST_W-1:0]   commit_dst,
  output logic [2:0]         commit_we,
  output logic [3*WIDTH-1:0] commit_data,
  output logic               busy
);
  localparam int N  = (WIDTH + FRAC) / 2;
  localparam int RW = 2 * N;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DST_W + 3 + 3 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [KW-1:0]    iter;
  logic             vec_q;
  logic [DST_W-1:0] dst_q;
  logic [2:0]       we_q;
  logic [RW-1:0]    rad      [3];
  logic [N+1:0]     rem      [3];
  logic [N-1:0]     root     [3];
  logic [RW-1:0]    rad_nxt  [3];
  logic [N+1:0]     rem_nxt  [3];
  logic [N-1:0]     root_nxt [3];
  logic [N+1:0]     rem_sh   [3];
  logic [N+1:0]     trial    [3];
  logic [WIDTH-1:0] op_in    [3];
  logic [WIDTH-1:0] res      [3];

  logic            accept;
  logic            push;
  logic            pop;
  logic [EW-1:0]   push_dat;
  logic [EW-1:0]   head;
  logic [CW-1:0]   count;

  assign accept = issue_valid && issue_ready;
  assign push   = (state == RUN) && (iter == '0);
  assign pop    = commit_granted && commit_request;

  // Scalar mode idles Y/Z; negative operands are zeroed so their root is 0.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      op_in[l] = operand[(3-l)*WIDTH-1 -: WIDTH];
      if ((l != 0) && !issue_vector) op_in[l] = '0;
      if (op_in[l][WIDTH-1]) op_in[l] = '0;
      rem_sh[l]  = (rem[l] << 2) | (N+2)'(rad[l][RW-1 -: 2]);
      trial[l]   = {root[l], 2'b01};
      rad_nxt[l] = rad[l] << 2;
      if (rem_sh[l] >= trial[l]) begin
        rem_nxt[l]  = rem_sh[l] - trial[l];
        root_nxt[l] = (root[l] << 1) | N'(1);
      end else begin
        rem_nxt[l]  = rem_sh[l];
        root_nxt[l] = root[l] << 1;
      end
      res[l] = WIDTH'(root_nxt[l]);
    end
  end

  assign push_dat = vec_q ? {dst_q, we_q, res[0], res[1], res[2]}
                          : {dst_q, we_q, res[0], res[0], res[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      iter  <= '0;
      vec_q <= 1'b0;
      dst_q <= '0;
      we_q  <= '0;
      for (int l = 0; l < 3; l++) begin
        rad[l]  <= '0;
        rem[l]  <= '0;
        root[l] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          iter  <= KW'(N - 1);
          vec_q <= issue_vector;
          dst_q <= issue_dst;
          we_q  <= issue_we;
          for (int l = 0; l < 3; l++) begin
            rad[l]  <= RW'(op_in[l]) << FRAC;
            rem[l]  <= '0;
            root[l] <= '0;
          end
        end
        RUN: begin
          iter <= iter - KW'(1);
          for (int l = 0; l < 3; l++) begin
            rad[l]  <= rad_nxt[l];
            rem[l]  <= rem_nxt[l];
            root[l] <= root_nxt[l];
          end
          if (iter == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sqrt_station_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign issue_ready    = (state == IDLE) && (count < CW'(DEPTH));
  assign commit_request = (count != '0);
  assign busy           = (state == RUN) || (count != '0);
  assign commit_id      = id;
  assign {commit_dst, commit_we, commit_data} = head;
endmodule

// File: tb/tb_sqrt_station_vec.sv
// Randomized bench for sqrt_station_vec against an integer-arithmetic square-root scoreboard.
module tb_sqrt_station_vec;
  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int DEPTH = 2;
  localparam int DST_W = 8;
  localparam int ID_W  = 4;
  localparam int N     = (WIDTH + FRAC) / 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ID_W-1:0]    id = 4'hA;
  logic               issue_valid = 1'b0;
  logic               issue_ready;
  logic               issue_vector = 1'b0;
  logic [DST_W-1:0]   issue_dst = '0;
  logic [2:0]         issue_we = '0;
  logic [3*WIDTH-1:0] operand = '0;
  logic               commit_request;
  logic               commit_granted = 1'b0;
  logic [ID_W-1:0]    commit_id;
  logic [DST_W-1:0]   commit_dst;
  logic [2:0]         commit_we;
  logic [3*WIDTH-1:0] commit_data;
  logic               busy;

  sqrt_station_vec #(.WIDTH(WIDTH), .FRAC(FRAC), .DEPTH(DEPTH), .DST_W(DST_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .id(id),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_vector(issue_vector),
    .issue_dst(issue_dst), .issue_we(issue_we), .operand(operand),
    .commit_request(commit_request), .commit_granted(commit_granted), .commit_id(commit_id),
    .commit_dst(commit_dst), .commit_we(commit_we), .commit_data(commit_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DST_W-1:0]   dst;
    logic [2:0]         we;
    logic [3*WIDTH-1:0] data;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   done = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // floor(sqrt(op * 2^FRAC)) built greedily from the square of each candidate.
  function automatic logic [WIDTH-1:0] sqrt_ref(input logic [WIDTH-1:0] op);
    longint unsigned r, t, rad;
    if (op[WIDTH-1]) return '0;
    rad = longint'(op) << FRAC;
    r = 0;
    for (int b = N - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= rad) r = t;
    end
    return WIDTH'(r);
  endfunction

  function automatic ent_t model(input logic vec, input logic [DST_W-1:0] dst,
                                 input logic [2:0] we, input logic [3*WIDTH-1:0] op);
    ent_t e;
    logic [WIDTH-1:0] x, y, z;
    x = sqrt_ref(op[3*WIDTH-1 -: WIDTH]);
    y = vec ? sqrt_ref(op[2*WIDTH-1 -: WIDTH]) : x;
    z = vec ? sqrt_ref(op[WIDTH-1:0]) : x;
    e.dst = dst;
    e.we = we;
    e.data = {x, y, z};
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_lane();
    logic [WIDTH-1:0] v;
    v = WIDTH'($urandom);
    if ($urandom_range(3) != 0) v[WIDTH-1] = 1'b0;
    if ($urandom_range(2) == 0) v = v >> $urandom_range(WIDTH - 1);
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (commit_granted && commit_request) begin
        if (sb.size() == 0) check("unexp_commit", 128'(commit_request), 128'(0));
        else begin
          mon_e = sb.pop_front();
          check("c_dst", 128'(commit_dst), 128'(mon_e.dst));
          check("c_we", 128'(commit_we), 128'(mon_e.we));
          check("c_data", 128'(commit_data), 128'(mon_e.data));
          check("c_id", 128'(commit_id), 128'(id));
        end
      end
      if (issue_valid && issue_ready)
        sb.push_back(model(issue_vector, issue_dst, issue_we, operand));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic vec, input logic [DST_W-1:0] dst,
                          input logic [2:0] we, input logic [3*WIDTH-1:0] op);
    int w = 0;
    issue_vector = vec;
    issue_dst = dst;
    issue_we = we;
    operand = op;
    issue_valid = 1'b1;
    while (!issue_ready && w < 500) begin
      tick();
      w++;
    end
    if (!issue_ready) check("issue_to", 128'(issue_ready), 128'(1));
    else tick();
    issue_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_req();
    int w = 0;
    while (!commit_request && w < 200) begin
      tick();
      w++;
    end
    if (!commit_request) check("req_to", 128'(commit_request), 128'(1));
  endtask

  task automatic grant();
    commit_granted = 1'b1;
    tick();
    commit_granted = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, 128'(issue_ready), 128'(1));
    check({tag, "_req"}, 128'(commit_request), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_dst"}, 128'(commit_dst), 128'(0));
    check({tag, "_we"}, 128'(commit_we), 128'(0));
    check({tag, "_data"}, 128'(commit_data), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a_cyc, seen, guard;
    logic [WIDTH-1:0] zr;
    #2;
    check_reset_outputs("rst0");
    tick();
    rst = 1'b0;
    tick();

    // Scalar 4.0 with junk on Y/Z; exact first-result latency.
    do_issue(1'b0, 8'h12, 3'b111, {32'h00040000, 32'hDEADBEEF, 32'h12345678});
    check("rdy_drop", 128'(issue_ready), 128'(0));
    check("busy_run", 128'(busy), 128'(1));
    repeat (N - 1) tick();
    check("lat_pre", 128'(commit_request), 128'(0));
    tick();
    check("lat_req", 128'(commit_request), 128'(1));
    check("lat_rdy", 128'(issue_ready), 128'(1));
    check("sc_data", 128'(commit_data), 128'({3{32'h00020000}}));
    check("sc_dst", 128'(commit_dst), 128'(8'h12));
    grant();
    check("sc_req_off", 128'(commit_request), 128'(0));
    check("sc_busy_off", 128'(busy), 128'(0));

    // Vector lanes with fixed expectations.
    do_issue(1'b1, 8'h34, 3'b101, {32'h00020000, 32'h00000000, 32'h7FFFFFFF});
    wait_req();
    check("vec_data", 128'(commit_data), 128'({32'h00016A09, 32'h00000000, 32'h00B504F3}));
    grant();

    // Negative X lane yields zero without disturbing Y/Z.
    zr = WIDTH'($urandom) & 32'h7FFFFFFF;
    do_issue(1'b1, 8'h56, 3'b011, {32'h80000000, 32'h00010000, zr});
    wait_req();
    check("neg_x", 128'(commit_data[3*WIDTH-1 -: WIDTH]), 128'(0));
    check("neg_y", 128'(commit_data[2*WIDTH-1 -: WIDTH]), 128'(32'h00010000));
    grant();

    // Grant while empty must be ignored.
    commit_granted = 1'b1;
    repeat (3) tick();
    commit_granted = 1'b0;
    check("empty_gnt_req", 128'(commit_request), 128'(0));
    check("empty_gnt_busy", 128'(busy), 128'(0));

    // Buffering: two fill the queue, the third waits for the first pop.
    do_issue(1'b0, 8'h01, 3'b111, {rnd_lane(), rnd_lane(), rnd_lane()});
    a_cyc = last_acc;
    do_issue(1'b1, 8'h02, 3'b110, {rnd_lane(), rnd_lane(), rnd_lane()});
    check("b2b_gap", 128'(last_acc - a_cyc), 128'(N + 1));
    issue_vector = 1'b1;
    issue_dst = 8'h03;
    issue_we = 3'b001;
    operand = {rnd_lane(), rnd_lane(), rnd_lane()};
    issue_valid = 1'b1;
    repeat (N) tick();
    check("full_req", 128'(commit_request), 128'(1));
    check("full_rdy", 128'(issue_ready), 128'(0));
    repeat (3) tick();
    check("full_rdy_hold", 128'(issue_ready), 128'(0));
    grant();
    check("rdy_after_pop", 128'(issue_ready), 128'(1));
    tick();
    issue_valid = 1'b0;

    // Push and pop at the same edge with one entry queued.
    repeat (N - 1) tick();
    grant();
    check("pp_req", 128'(commit_request), 128'(1));
    check("pp_rdy", 128'(issue_ready), 128'(1));
    if (sb.size() == 1) begin
      check("pp_head_data", 128'(commit_data), 128'(sb[0].data));
      check("pp_head_dst", 128'(commit_dst), 128'(sb[0].dst));
    end else check("pp_sb_size", 128'(sb.size()), 128'(1));
    grant();
    check("pp_drain_busy", 128'(busy), 128'(0));

    // Async reset mid-iteration with one queued entry.
    do_issue(1'b0, 8'h44, 3'b111, {rnd_lane(), rnd_lane(), rnd_lane()});
    wait_req();
    do_issue(1'b1, 8'h45, 3'b111, {rnd_lane(), rnd_lane(), rnd_lane()});
    repeat (9) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (N + 5) begin
      tick();
      if (commit_request || busy) seen++;
    end
    check("no_req_after_rst", 128'(seen), 128'(0));
    do_issue(1'b0, 8'h77, 3'b010, {32'h00090000, 32'h0, 32'h0});
    wait_req();
    check("post_rst_data", 128'(commit_data), 128'({3{32'h00030000}}));
    check("post_rst_dst", 128'(commit_dst), 128'(8'h77));
    grant();

    // Randomized issue/grant traffic checked by the scoreboard.
    done = 0;
    fork
      begin
        for (int i = 0; i < 24; i++)
          do_issue(1'($urandom), DST_W'($urandom), 3'($urandom),
                   {rnd_lane(), rnd_lane(), rnd_lane()});
        done = 1;
      end
      begin
        guard = 0;
        while (!(done && sb.size() == 0) && guard < 20000) begin
          commit_granted = ($urandom_range(2) == 0);
          tick();
          guard++;
        end
        commit_granted = 1'b0;
        if (guard >= 20000) check("drain_to", 128'(sb.size()), 128'(0));
      end
    join
    tick();
    check("final_busy", 128'(busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sqrt_station_vec.md
# sqrt_station_vec

Parametrised square-root execution station: accepts one issue per operation, computes an unsigned fixed-point square root on one lane (scalar mode) or all three lanes (vector mode), and buffers results in a DEPTH-entry commit queue arbitrated onto the shared commit bus. It is the next-generation replacement for the single-operand, single-result square-root station in the execution cluster. It adds width/precision parameters, vector mode, and result buffering so that a granted-late commit does not block the next issue.

## Interface
Parameters:
- WIDTH, 32, lane width in bits; fixed-point two's-complement operand.
- FRAC, 16, fractional bits; WIDTH+FRAC must be even.
- DEPTH, 2, commit-queue entries (≥1).
- DST_W, 8, destination-register field width.
- ID_W, 4, station id width.

Ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- iId  in  ID_W  static station id, echoed on oCommitId.
- iIssueValid  in  1  issue request.
- oIssueReady  out  1  issue accepted at an edge where iIssueValid&&oIssueReady.
- iIssueVector  in  1  1 = sqrt X,Y,Z independently; 0 = sqrt X only, broadcast to all lanes.
- iIssueDst  in  DST_W  destination register.
- iIssueWE  in  3  lane write-enable {X,Y,Z}.
- iOperand  in  3*WIDTH  {X,Y,Z}, X in MSBs.
- oCommitRequest  out  1  queue non-empty.
- iCommitGranted  in  1  pops queue head.
- oCommitId  out  ID_W  = iId.
- oCommitDst  out  DST_W  head destination.
- oCommitWE  out  3  head write-enable.
- oCommitData  out  3*WIDTH  head result {X,Y,Z}.
- oBusy  out  1  engine active OR queue non-empty.

## Operation
- N = (WIDTH+FRAC)/2 iterations; default N = 24.
- Per lane: radicand R = operand << FRAC (WIDTH+FRAC bits). Result = floor(sqrt(R)), N bits, zero-extended to WIDTH.
- Operand MSB set (negative): that lane's result = 0. No exception is raised.
- Engine: bit-serial restoring sqrt, one result bit per cycle, MSB first. There are three lane datapaths. In scalar mode, Y and Z datapaths are idle (operand forced 0), and X's result is copied to all three lanes at queue write.
- State machine:
  - IDLE: on an accepted issue, latch operands/dst/we/mode, clear the partial remainder and root, set iteration counter = N-1, go to RUN.
  - RUN: one iteration per cycle. When counter = 0, write {dst, we, results} to the queue tail and go to IDLE.
- oIssueReady = (state==IDLE) && (count < DEPTH). Because the slot check is done at issue, the engine never stalls waiting for queue space.
- Queue: first-word-fall-through FIFO with circular read/write pointers that wrap at DEPTH and a count 0..DEPTH. Head fields drive oCommit* combinationally; they are don't-care when count==0.
- A pop occurs only at an edge where iCommitGranted && oCommitRequest. Grant while the queue is empty is ignored.
- Push and pop at the same edge: count unchanged, both pointers advance. This is legal when full, because a push can only occur if the slot was reserved at issue.

## Timing
- Reset values:
  - oIssueReady=1, oCommitRequest=0, oBusy=0.
  - oCommitDst/oCommitWE/oCommitData=0.
  - state=IDLE, count=0, pointers=0.
- Reset mid-RUN or with a non-empty queue drops all in-flight and queued results; no commit follows.
- Latency: with the issue accepted at edge E0, iterations run at E1..EN and the queue write happens at EN. oCommitRequest is high in the cycle after EN, provided the queue was empty.
- oIssueReady drops the cycle after E0 and returns the cycle after EN if count<DEPTH. Back-to-back throughput is one op per N+1 cycles.
- Commit handshake: oCommitRequest stays high until granted, with head fields stable. After a pop, the next entry (if any) is presented in the following cycle.
- oBusy is high from the cycle after E0 until the cycle after the pop of the last entry.

## Test plan
- Scalar, FRAC=16: X=0x00040000 (4.0), WE=3'b111, dst=0x12. After 24 cycles: request high, data {0x00020000 ×3}, dst 0x12. Grant for one cycle: request low, oBusy low.
- Vector: {0x00020000, 0x00000000, 0x7FFFFFFF} → {0x00016A09, 0x00000000, 0x00B504F3}. Also check that Y/Z lane operands are ignored in scalar mode.
- Negative: X=0x80000000, vector mode with Y=0x00010000 → {0x00000000, 0x00010000, Z-result}.
- Buffering: DEPTH=2, grant held low, three issues back-to-back. Two are accepted ~25 cycles apart; oIssueReady stays low after the second completes. The third is accepted in the cycle after the first grant. Commit order is FIFO.
- Simultaneous push/pop with the queue at count=1: grant at the edge the second result is written → count stays 1, and the correct entry is at the head next cycle.
- Async Reset asserted at iteration 10 with one queued entry: all outputs return to reset values immediately. No request follows, and a fresh issue is accepted after Reset deasserts.
